// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle for seq_alu.
//   master : operand producer / result consumer (decode + writeback side)
//   slave  : the ALU itself
// Signals:
//   in_valid/in_ready            operand handshake
//   in_data1, in_data2           operands A and B (WIDTH bits)
//   in_select                    {m_ext, funct3[2:0], funct7[5]}
//   out_valid/out_ready          result handshake
//   out_data                     result (WIDTH bits)
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [4:0]       in_select;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data1, in_data2, in_select, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data1, in_data2, in_select, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked RV32I/RV64I integer ALU with optional iterative
// M-extension (radix-2 shift-add multiply, restoring divide).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    seq_alu_if.slave (operand and result valid/ready handshakes)
// Latency: base/illegal ops 1 cycle after accept, M ops WIDTH+1 cycles.
// Build option: define SEQ_ALU_MULDIV_EN to compile in the multiply/divide
// datapath; without it any op with in_select[4]=1 returns 0 after 1 cycle.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [4:0]       sel_q;
  logic             accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] base_res;
  logic [WIDTH-1:0] result;

  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign shamt         = b_q[SHAMT_W-1:0];

  // Base ops evaluate from operands captured at accept.
  always_comb begin
    // NOTE: default first so no path through the case leaves base_res
    // unassigned, which would infer a latch.
    base_res = '0;
    case (sel_q[3:0])
      4'b0000: base_res = a_q + b_q;
      4'b0001: base_res = a_q - b_q;
      4'b0010: base_res = a_q << shamt;
      4'b0100: base_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      4'b0110: base_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      4'b1000: base_res = a_q ^ b_q;
      4'b1010: base_res = a_q >> shamt;
      4'b1011: base_res = $signed(a_q) >>> shamt;
      4'b1100: base_res = a_q | b_q;
      4'b1110: base_res = a_q & b_q;
      default: base_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // Shared iterative datapath. Multiply: acc holds the running high half,
  // lo the multiplier shifting out LSB-first and the product low half
  // shifting in. Divide: lo holds the dividend shifting out MSB-first and
  // the quotient shifting in, acc the partial remainder.
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d, opb_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               sa_q, sx_q, div0_q;
  logic [2:0]         fn;
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo, rem, m_res;

  assign fn       = bus.in_select[3:1];
  assign a_signed = (fn == 3'b001) || (fn == 3'b010) || (fn == 3'b100) || (fn == 3'b110);
  assign b_signed = (fn == 3'b001) || (fn == 3'b100) || (fn == 3'b110);
  assign a_neg    = a_signed && bus.in_data1[WIDTH-1];
  assign b_neg    = b_signed && bus.in_data2[WIDTH-1];
  assign mag_a    = a_neg ? -bus.in_data1 : bus.in_data1;
  assign mag_b    = b_neg ? -bus.in_data2 : bus.in_data2;

  always_comb begin
    acc_d     = acc_q;
    lo_d      = lo_q;
    mul_sum   = lo_q[0] ? acc_q + {1'b0, opb_q} : acc_q;
    div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    // One extra bit so the borrow is visible even when div_shift >= 2^WIDTH.
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    if (sel_q[3]) begin
      if (div_diff[WIDTH+1]) begin
        acc_d = div_shift;
        lo_d  = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = div_diff[WIDTH:0];
        lo_d  = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_d = {1'b0, mul_sum[WIDTH:1]};
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up. Divide-by-zero forces an all-ones quotient; the remainder
  // (|A| with A's sign) already equals A. MIN/-1 falls out naturally.
  assign prod   = {acc_q[WIDTH-1:0], lo_q};
  assign prod_s = sx_q ? -prod : prod;
  assign quo    = div0_q ? '1 : (sx_q ? -lo_q : lo_q);
  assign rem    = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_comb begin
    m_res = '0;
    case (sel_q[3:1])
      3'b000:                 m_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: m_res = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         m_res = quo;
      default:                m_res = rem;
    endcase
  end

  assign result = sel_q[4] ? m_res : base_res;
`else
  assign result = sel_q[4] ? '0 : base_res;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too; they are few and a
      // known state keeps post-reset results free of X.
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
`ifdef SEQ_ALU_MULDIV_EN
      acc_q       <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      sa_q        <= 1'b0;
      sx_q        <= 1'b0;
      div0_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q   <= bus.in_data1;
            b_q   <= bus.in_data2;
            sel_q <= bus.in_select;
            state_q <= DONE;
`ifdef SEQ_ALU_MULDIV_EN
            if (bus.in_select[4]) begin
              state_q <= BUSY;
              cnt_q   <= SHAMT_W'(WIDTH - 1);
              acc_q   <= '0;
              lo_q    <= mag_a;
              opb_q   <= mag_b;
              sa_q    <= a_neg;
              sx_q    <= a_neg ^ b_neg;
              div0_q  <= fn[2] && (bus.in_data2 == '0);
            end
`endif
          end
        end
`ifdef SEQ_ALU_MULDIV_EN
        BUSY: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          if (cnt_q == '0) state_q <= DONE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
`endif
        DONE: begin
          // First DONE cycle registers the result; afterwards hold until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= result;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=32). Expected results are
// queued at accept and compared, with latency, when out_valid rises.
module tb_seq_alu;
  localparam int WIDTH = 32;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  seq_alu_if #(.WIDTH(WIDTH)) bus ();
  seq_alu #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model built on native 64-bit arithmetic.
  function automatic logic [31:0] ref_alu(input logic [4:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    int sa, sbv;
    sa  = a;
    sbv = b;
    if (sel[4]) begin
      if (!MULDIV) return 32'h0;
      case (sel[3:1])
        3'b000: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
        3'b001: begin p = longint'(sa) * longint'(sbv); return p[63:32]; end
        3'b010: begin p = longint'(sa) * longint'({32'h0, b}); return p[63:32]; end
        3'b011: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
        3'b100: begin
          if (b == 32'h0) return 32'hFFFF_FFFF;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
          return sa / sbv;
        end
        3'b101: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
        3'b110: begin
          if (b == 32'h0) return a;
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
          return sa % sbv;
        end
        default: return (b == 32'h0) ? a : a % b;
      endcase
    end
    case (sel[3:0])
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a << b[4:0];
      4'b0100: return (sa < sbv) ? 32'h1 : 32'h0;
      4'b0110: return (a < b) ? 32'h1 : 32'h0;
      4'b1000: return a ^ b;
      4'b1010: return a >> b[4:0];
      4'b1011: return sa >>> b[4:0];
      4'b1100: return a | b;
      4'b1110: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  // Drive one op, push its expectation, wait (bounded) for the result,
  // compare data and latency, then take it and check the handshake returns.
  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int   n;
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_select = sel;
    bus.in_data1  = a;
    bus.in_data2  = b;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    sb.push_back('{tag, exp, (sel[4] && MULDIV) ? WIDTH + 1 : 1});
    // Scramble inputs after accept: captured operands must be unaffected.
    bus.in_valid  = 1'b0;
    bus.in_data1  = $urandom;
    bus.in_data2  = $urandom;
    bus.in_select = 5'($urandom);
    waited = 0;
    while (!bus.out_valid && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    e = sb.pop_front();
    check({e.tag, "/data"}, 64'(bus.out_data), 64'(e.data));
    check({e.tag, "/latency"}, 64'(cyc - n), 64'(e.lat));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "/xfer_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "/xfer_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  logic [4:0] legal_sel [18] = '{
    5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00110, 5'b01000, 5'b01010, 5'b01011,
    5'b01100, 5'b01110, 5'b10000, 5'b10011, 5'b10100, 5'b10110, 5'b11000, 5'b11010,
    5'b11100, 5'b11110
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int pre;
    logic [4:0]  s;
    logic [31:0] ra, rb;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data1  = '0;
    bus.in_data2  = '0;
    bus.in_select = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/out_valid", 64'(bus.out_valid), 64'd0);
    check("reset/out_data", 64'(bus.out_data), 64'd0);
    check("reset/in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset/in_ready_after", 64'(bus.in_ready), 64'd1);

    // Base ops.
    run_op("add",  5'b00000, 32'd7, 32'd5, 32'd12);
    run_op("sub",  5'b00001, 32'd5, 32'd7, 32'hFFFF_FFFE);
    run_op("sra",  5'b01011, 32'h8000_0000, 32'h24, 32'hF800_0000);
    run_op("srl",  5'b01010, 32'h8000_0000, 32'h24, 32'h0800_0000);
    run_op("sltu", 5'b00110, 32'd1, 32'hFFFF_FFFF, 32'd1);
    run_op("slt",  5'b00100, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_op("sll",  5'b00010, 32'h0000_0003, 32'h21, 32'h0000_0006);
    run_op("xor",  5'b01000, 32'hF0F0_1234, 32'h0FF0_4321, 32'hFF00_5115);
    run_op("or",   5'b01100, 32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011);
    run_op("and",  5'b01110, 32'hF0F0_FFFF, 32'h0FF0_1234, 32'h00F0_1234);
    run_op("illegal", 5'b00011, 32'd9, 32'd9, 32'd0);

    // M ops (all return 0 with latency 1 when the datapath is compiled out).
    run_op("mul",    5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULDIV ? 32'h1 : 32'h0);
    run_op("mul34",  5'b10001, 32'd3, 32'd4, MULDIV ? 32'd12 : 32'd0);
    run_op("mulhu",  5'b10110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULDIV ? 32'hFFFF_FFFE : 32'h0);
    run_op("mulh",   5'b10010, 32'h8000_0000, 32'h8000_0000, MULDIV ? 32'h4000_0000 : 32'h0);
    run_op("mulhsu", 5'b10100, 32'hFFFF_FFFF, 32'd2, MULDIV ? 32'hFFFF_FFFF : 32'h0);
    run_op("div",    5'b11000, 32'hFFFF_FFF9, 32'd2, MULDIV ? 32'hFFFF_FFFD : 32'h0);
    run_op("rem",    5'b11100, 32'hFFFF_FFF9, 32'd2, MULDIV ? 32'hFFFF_FFFF : 32'h0);
    run_op("divu0",  5'b11010, 32'd10, 32'd0, MULDIV ? 32'hFFFF_FFFF : 32'h0);
    run_op("remu0",  5'b11110, 32'd10, 32'd0, MULDIV ? 32'd10 : 32'h0);
    run_op("div0s",  5'b11000, 32'hFFFF_FFF9, 32'd0, MULDIV ? 32'hFFFF_FFFF : 32'h0);
    run_op("divovf", 5'b11000, 32'h8000_0000, 32'hFFFF_FFFF, MULDIV ? 32'h8000_0000 : 32'h0);
    run_op("removf", 5'b11100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Random legal ops against the model.
    for (int i = 0; i < 16; i++) begin
      s  = legal_sel[$urandom_range(17, 0)];
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'h0 : ((i % 4 == 1) ? 32'($urandom_range(9, 1)) : $urandom);
      run_op($sformatf("rand%0d_sel%05b", i, s), s, ra, rb, ref_alu(s, ra, rb));
    end

    // Stall in DONE with new operands offered: nothing may change.
    @(negedge clk);
    bus.in_select = 5'b00000;
    bus.in_data1  = 32'd100;
    bus.in_data2  = 32'd23;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_data1 = 32'd1;
    bus.in_data2 = 32'd1;
    @(posedge clk);
    #1;
    check("stall/first_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d/data", i), 64'(bus.out_data), 64'd123);
      check($sformatf("stall%0d/valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("stall%0d/in_ready", i), 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("stall/xfer_valid", 64'(bus.out_valid), 64'd0);
    check("stall/hold_data", 64'(bus.out_data), 64'd123);
    repeat (2) @(posedge clk);
    #1;
    check("stall/no_second_accept", 64'(bus.out_valid), 64'd0);
    check("stall/idle_ready", 64'(bus.in_ready), 64'd1);

    // Reset in the middle of a DIV: its result must never appear.
    seen = 0;
    pre  = MULDIV ? 9 : 0;
    @(negedge clk);
    bus.in_select = 5'b11000;
    bus.in_data1  = 32'd100;
    bus.in_data2  = 32'd7;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < pre; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst/in_ready_low", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    if (bus.out_valid) seen++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst/in_ready_after", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("rst/never_valid", 64'(seen), 64'd0);

    // Block works normally after the mid-op reset.
    run_op("post_rst_divu", 5'b11010, 32'd100, 32'd7, MULDIV ? 32'd14 : 32'd0);
    run_op("post_rst_add", 5'b00000, 32'hFFFF_FFFF, 32'd2, 32'd1);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
